life_gen_engine: RTL and testbench
==================================

LIFE_GEN_ENGINE -- requirements
Module: life_gen_engine

Interface
REQ-001 SHALL have parameter FIELD_W, default 32, field width in cells.
REQ-002 SHALL have parameter FIELD_H, default 15, field height in cells.
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_start  input  1  pulse to begin computing one generation.
REQ-006 SHALL have port o_busy  output  1  high while a generation is being computed.
REQ-007 SHALL have port o_done  output  1  one-cycle pulse when the generation is complete.
REQ-008 SHALL have port o_rd_en  output  1  current-generation RAM read strobe.
REQ-009 SHALL have ports o_rd_x / o_rd_y  output  $clog2(FIELD_W) / $clog2(FIELD_H)  read address.
REQ-010 SHALL have port i_rd_data  input  1  cell value, valid exactly one cycle after o_rd_en.
REQ-011 SHALL have port o_wr_en  output  1  next-generation RAM write strobe.
REQ-012 SHALL have ports o_wr_x / o_wr_y  output  same widths as the read address  write address.
REQ-013 SHALL have port o_wr_data  output  1  next-generation cell value.

Function
REQ-014 SHALL implement FSM states IDLE, READ, DRAIN, WRITE and DONE.
REQ-015 In IDLE, i_start=1 SHALL load cell (0,0), clear the neighbour count and go to READ; i_start in any other state SHALL be ignored.
REQ-016 READ SHALL last 9 cycles with slot k=0..8 at offset dy=k/3-1, dx=k%3-1; slot 4 is the cell itself.
REQ-017 Each slot SHALL drive o_rd_x/o_rd_y to the neighbour coordinate; i_rd_data of slot k SHALL be accumulated in the following cycle.
REQ-018 DRAIN (1 cycle) SHALL accumulate slot 8; WRITE (1 cycle) SHALL assert o_wr_en with o_wr_x/o_wr_y equal to the current cell.
REQ-019 The neighbour count SHALL be 4 bits over the 8 non-self slots; o_wr_data = (n==3) | (self & n==2).
REQ-020 Each cell SHALL take exactly 11 cycles; cells SHALL be visited in raster order, x fastest.
REQ-021 After WRITE, the engine SHALL take the next cell from the raster successor; if the cell was (FIELD_W-1,FIELD_H-1), it SHALL go to DONE instead.
REQ-022 DONE SHALL assert o_done for one cycle and then go to IDLE.
REQ-023 o_busy SHALL be 1 in READ, DRAIN, WRITE and DONE, and 0 in IDLE.
REQ-024 With start sampled at edge t, the first write SHALL occur in cycle t+11 and o_done SHALL be high in cycle t+11*FIELD_W*FIELD_H+1.

Reset
REQ-025 While i_rst_n=0, the state SHALL be IDLE and all outputs, the count, and the coordinates SHALL be 0.
REQ-026 Reset mid-generation SHALL abort immediately, with no further o_wr_en and no o_done.

Configuration
REQ-027 With LIFE_TORUS_EN defined, neighbour coordinates SHALL wrap modulo FIELD_W/FIELD_H.
REQ-028 Without LIFE_TORUS_EN, out-of-field slots SHALL keep o_rd_en=0 and count as dead; slot timing stays 11 cycles per cell.

Structure
REQ-029 Package life_pkg SHALL hold the FSM state enum, the slot count (9), the self-slot index (4) and the address-width localparams.
REQ-030 The raster advance SHALL be done by one instance of the existing sub-module get_next_coords; no other sub-module.

Verification (FIELD_W=8, FIELD_H=5)
REQ-031 All-dead field, start -> 40 writes in raster order, all o_wr_data=0; first write (0,0), last (7,4); o_done in cycle t+441.
REQ-032 Horizontal blinker at (2,2),(3,2),(4,2) -> 1s written only at (3,1),(3,2),(3,3).
REQ-033 Cells (0,1),(0,2),(0,3) with LIFE_TORUS_EN -> 1s at (7,2),(0,2),(1,2); without LIFE_TORUS_EN -> 1s at (0,2),(1,2) only.
REQ-034 Cell (0,0) with LIFE_TORUS_EN -> first read address (7,4); without LIFE_TORUS_EN -> slots 0,1,2,3,6 have o_rd_en=0.
REQ-035 i_start pulsed at cycle t+50 while busy -> no restart; o_done still in cycle t+441.
REQ-036 i_rst_n low at cycle t+100 -> o_busy=0 and o_wr_en=0 thereafter; a new start then runs a full generation from (0,0).

Source files
------------

// File: rtl/life_pkg.sv
// life_pkg: shared FSM state, slot geometry and default field/address widths for the Life engine.
package life_pkg;
  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} life_state_e;
  localparam int SLOTS = 9;
  localparam int SELF_SLOT = 4;
  localparam int SLOT_W = $clog2(SLOTS);
  localparam int LIFE_W = 32;
  localparam int LIFE_H = 15;
  localparam int LIFE_XW = $clog2(LIFE_W);
  localparam int LIFE_YW = $clog2(LIFE_H);
  function automatic logic [1:0] slot_col(input logic [SLOT_W-1:0] s);
    return 2'(s % SLOT_W'(3));
  endfunction
  function automatic logic [1:0] slot_row(input logic [SLOT_W-1:0] s);
    return 2'(s / SLOT_W'(3));
  endfunction
endpackage

// File: rtl/get_next_coords.sv
// get_next_coords: raster successor of (x,y), x fastest; wraps to (0,0) after the last cell.
module get_next_coords import life_pkg::*; #(
  parameter int W = LIFE_W,
  parameter int H = LIFE_H,
  parameter int XW = LIFE_XW,
  parameter int YW = LIFE_YW
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [XW-1:0] nx,
  output logic [YW-1:0] ny,
  output logic          last
);
  logic x_end;
  assign x_end = x == XW'(W - 1);
  assign last = x_end && y == YW'(H - 1);
  assign nx = x_end ? '0 : x + 1'b1;
  assign ny = last ? '0 : x_end ? y + 1'b1 : y;
endmodule

// File: rtl/life_gen_engine.sv
// life_gen_engine: computes one Game of Life generation cell by cell, 11 cycles per cell.
// Define LIFE_TORUS_EN to wrap neighbour coordinates; otherwise off-field neighbours read as dead.
module life_gen_engine import life_pkg::*; #(
  parameter int FIELD_W = LIFE_W,
  parameter int FIELD_H = LIFE_H
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_rd_en,
  output logic [$clog2(FIELD_W)-1:0] o_rd_x,
  output logic [$clog2(FIELD_H)-1:0] o_rd_y,
  input  logic                       i_rd_data,
  output logic                       o_wr_en,
  output logic [$clog2(FIELD_W)-1:0] o_wr_x,
  output logic [$clog2(FIELD_H)-1:0] o_wr_y,
  output logic                       o_wr_data
);
  localparam int XW = $clog2(FIELD_W);
  localparam int YW = $clog2(FIELD_H);
  life_state_e state, state_nx;
  logic [SLOT_W-1:0] slot, slot_d;
  logic [XW-1:0] cx, nx_c, rx_raw, rx;
  logic [YW-1:0] cy, ny_c, ry_raw, ry;
  logic [3:0] count;
  logic [1:0] col, row;
  logic self_q, rd_pend, last, in_field, x_lo, x_hi, y_lo, y_hi;
  get_next_coords #(.W(FIELD_W), .H(FIELD_H), .XW(XW), .YW(YW)) u_next (
    .x(cx), .y(cy), .nx(nx_c), .ny(ny_c), .last(last)
  );
  assign col = slot_col(slot);
  assign row = slot_row(slot);
  assign x_lo = col == 2'd0 && cx == '0;
  assign x_hi = col == 2'd2 && cx == XW'(FIELD_W - 1);
  assign y_lo = row == 2'd0 && cy == '0;
  assign y_hi = row == 2'd2 && cy == YW'(FIELD_H - 1);
  assign rx_raw = cx + XW'(col) - XW'(1);
  assign ry_raw = cy + YW'(row) - YW'(1);
`ifdef LIFE_TORUS_EN
  assign rx = x_lo ? XW'(FIELD_W - 1) : x_hi ? '0 : rx_raw;
  assign ry = y_lo ? YW'(FIELD_H - 1) : y_hi ? '0 : ry_raw;
  assign in_field = 1'b1;
`else
  assign rx = rx_raw;
  assign ry = ry_raw;
  assign in_field = !(x_lo || x_hi || y_lo || y_hi);
`endif
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
  assign o_rd_en = state == READ && in_field;
  assign o_rd_x = state == READ ? rx : '0;
  assign o_rd_y = state == READ ? ry : '0;
  assign o_wr_en = state == WRITE;
  assign o_wr_x = o_wr_en ? cx : '0;
  assign o_wr_y = o_wr_en ? cy : '0;
  assign o_wr_data = o_wr_en && (count == 4'd3 || (self_q && count == 4'd2));
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = i_start ? READ : IDLE;
      READ:  state_nx = slot == SLOT_W'(SLOTS - 1) ? DRAIN : READ;
      DRAIN: state_nx = WRITE;
      WRITE: state_nx = last ? DONE : READ;
      default: state_nx = IDLE;
    endcase
  end
  // read data lags its slot by one cycle, so accumulate against the delayed slot index
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      slot <= '0;
      slot_d <= '0;
      cx <= '0;
      cy <= '0;
      count <= '0;
      self_q <= 1'b0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= o_rd_en;
      slot_d <= slot;
      slot <= state == READ && slot != SLOT_W'(SLOTS - 1) ? slot + 1'b1 : '0;
      if (rd_pend && slot_d == SLOT_W'(SELF_SLOT)) self_q <= i_rd_data;
      if (rd_pend && slot_d != SLOT_W'(SELF_SLOT)) count <= count + 4'(i_rd_data);
      if (state == WRITE || (state == IDLE && i_start)) begin
        count <= '0;
        self_q <= 1'b0;
      end
      if (state == IDLE && i_start) begin
        cx <= '0;
        cy <= '0;
      end
      if (state == WRITE) begin
        cx <= nx_c;
        cy <= ny_c;
      end
    end
endmodule

// File: tb/tb_life_gen_engine.sv
// tb_life_gen_engine: scoreboard bench on an 8x5 field; honours LIFE_TORUS_EN like the design.
module tb_life_gen_engine;
  localparam int W = 8;
  localparam int H = 5;
  localparam int N = W * H;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_rd_data = 1'b0;
  logic o_busy, o_done, o_rd_en, o_wr_en, o_wr_data;
  logic [2:0] o_rd_x, o_rd_y, o_wr_x, o_wr_y;
  int n_vec = 0, n_err = 0, cyc = 0;
  bit cur [N];
  typedef struct {int x; int y; int d;} wr_t;
  wr_t exp_q[$];
  life_gen_engine #(.FIELD_W(W), .FIELD_H(H)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_rd_en(o_rd_en), .o_rd_x(o_rd_x), .o_rd_y(o_rd_y), .i_rd_data(i_rd_data),
    .o_wr_en(o_wr_en), .o_wr_x(o_wr_x), .o_wr_y(o_wr_y), .o_wr_data(o_wr_data)
  );
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    i_rd_data <= o_rd_en ? cur[(int'(o_rd_y) * W + int'(o_rd_x)) % N] : 1'b0;
  end
  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int next_cell(input int x, input int y);
    int n = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        int xx = x + dx, yy = y + dy;
        if (dx == 0 && dy == 0) continue;
`ifdef LIFE_TORUS_EN
        xx = (xx + W) % W;
        yy = (yy + H) % H;
`else
        if (xx < 0 || xx >= W || yy < 0 || yy >= H) continue;
`endif
        n += int'(cur[yy * W + xx]);
      end
    return int'(n == 3 || (cur[y * W + x] && n == 2));
  endfunction
  task automatic check_idle(input string tag);
    check({tag, "_busy"}, int'(o_busy), 0);
    check({tag, "_wr_en"}, int'(o_wr_en), 0);
    check({tag, "_done"}, int'(o_done), 0);
  endtask
  task automatic run_gen(input int poke_at, input bit abort);
    int nw = 0;
    bit fin = 1'b0;
    wr_t e;
    exp_q.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) exp_q.push_back('{x, y, next_cell(x, y)});
    @(negedge i_clk);
    i_start = 1'b1;
    for (int k = 1; k <= 460 && !fin; k++) begin
      @(negedge i_clk);
      i_start = k == poke_at;
      if (k <= 9) begin
        int s = k - 1, ex = s % 3 - 1, ey = s / 3 - 1, en;
`ifdef LIFE_TORUS_EN
        ex = (ex + W) % W;
        ey = (ey + H) % H;
        en = 1;
`else
        en = int'(ex >= 0 && ey >= 0);
`endif
        check("rd_en", int'(o_rd_en), en);
        if (en != 0) begin
          check("rd_x", int'(o_rd_x), ex);
          check("rd_y", int'(o_rd_y), ey);
        end
      end
      if (o_wr_en) begin
        if (exp_q.size() == 0) check("extra_wr", 1, 0);
        else begin
          e = exp_q.pop_front();
          nw++;
          check("wr_x", int'(o_wr_x), e.x);
          check("wr_y", int'(o_wr_y), e.y);
          check("wr_data", int'(o_wr_data), e.d);
          check("wr_cyc", k, 11 * nw);
          check("wr_busy", int'(o_busy), 1);
        end
      end
      if (o_done) begin
        check("done_cyc", k, 11 * N + 1);
        fin = 1'b1;
      end
      if (abort && k == 100) begin
        i_rst_n = 1'b0;
        repeat (5) begin
          @(negedge i_clk);
          check_idle("rst_hold");
        end
        i_rst_n = 1'b1;
        repeat (20) begin
          @(negedge i_clk);
          check_idle("post_abort");
        end
        fin = 1'b1;
        exp_q.delete();
      end
    end
    i_start = 1'b0;
    if (!abort) begin
      check("done_seen", int'(fin), 1);
      check("wr_count", nw, N);
      check("q_left", exp_q.size(), 0);
      @(negedge i_clk);
      check_idle("after_done");
    end
  endtask
  initial begin
    repeat (3) @(negedge i_clk);
    check_idle("reset");
    check("reset_rd_en", int'(o_rd_en), 0);
    check("reset_rd_xy", int'({o_rd_x, o_rd_y, o_wr_x, o_wr_y}), 0);
    check("reset_wr_data", int'(o_wr_data), 0);
    i_rst_n = 1'b1;
    foreach (cur[i]) cur[i] = 1'b0;
    run_gen(50, 1'b0);
    foreach (cur[i]) cur[i] = 1'b0;
    cur[2 * W + 2] = 1'b1;
    cur[2 * W + 3] = 1'b1;
    cur[2 * W + 4] = 1'b1;
    run_gen(0, 1'b0);
    foreach (cur[i]) cur[i] = 1'b0;
    cur[1 * W] = 1'b1;
    cur[2 * W] = 1'b1;
    cur[3 * W] = 1'b1;
    run_gen(0, 1'b0);
    foreach (cur[i]) cur[i] = 1'($urandom_range(1));
    run_gen(0, 1'b1);
    run_gen(0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
